// File: rtl/mult_sequencer_if.sv
// Handshake and datapath bundle between the shift-and-add control FSM and its user.
// The sequencer takes the slave side; the requester / accumulator side takes master.
interface mult_sequencer_if #(
  parameter int unsigned DW = 8
);
  logic              i_start;
  logic [DW-1:0]     i_multiplicand;
  logic [DW-1:0]     i_multiplier;
  logic              o_clean;
  logic              o_enable;
  logic [2*DW-1:0]   o_val;
  logic              o_stop;
  logic              o_busy;
  logic              o_ready;

  modport slave (
    input  i_start, i_multiplicand, i_multiplier,
    output o_clean, o_enable, o_val, o_stop, o_busy, o_ready
  );

  modport master (
    output i_start, i_multiplicand, i_multiplier,
    input  o_clean, o_enable, o_val, o_stop, o_busy, o_ready
  );
endinterface

// File: rtl/mult_sequencer.sv
// Control FSM for a shift-and-add multiplier: owns the operand shift registers and
// steers an external accumulator one multiplier bit per clock, fixed DW+2 latency.
module mult_sequencer #(
  parameter int unsigned DW = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  mult_sequencer_if.slave   bus
);

  localparam int unsigned CW = $clog2(DW) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CALC,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [2*DW-1:0] mcand_q, mcand_d;
  logic [DW-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  // Outputs depend only on state and registers, so reset clears them immediately.
  always_comb begin
    state_d      = state_q;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    cnt_d        = cnt_q;
    bus.o_clean  = 1'b0;
    bus.o_enable = 1'b0;
    bus.o_val    = '0;
    bus.o_stop   = 1'b0;
    bus.o_busy   = 1'b0;
    bus.o_ready  = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (state_q == S_DONE) begin
          bus.o_ready = 1'b1;
          bus.o_stop  = 1'b1;
        end
        if (bus.i_start) begin
          mcand_d  = {{DW{1'b0}}, bus.i_multiplicand};
          mplier_d = bus.i_multiplier;
          cnt_d    = '0;
          state_d  = S_LOAD;
        end
      end

      S_LOAD: begin
        bus.o_clean = 1'b1;
        bus.o_busy  = 1'b1;
        state_d     = S_CALC;
      end

      S_CALC: begin
        bus.o_busy   = 1'b1;
        bus.o_val    = mcand_q;
        bus.o_enable = mplier_q[0];
        mcand_d      = mcand_q << 1;
        mplier_d     = mplier_q >> 1;
        cnt_d        = cnt_q + 1'b1;
        if (cnt_q == CW'(DW - 1)) begin
          state_d = S_DONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  a_clean_enable_excl: assert property (@(posedge i_clk) disable iff (i_rst)
    !(bus.o_clean && bus.o_enable));

  a_stop_only_done: assert property (@(posedge i_clk) disable iff (i_rst)
    bus.o_stop |-> (state_q == S_DONE));

  a_busy_ready_excl: assert property (@(posedge i_clk) disable iff (i_rst)
    !(bus.o_busy && bus.o_ready));

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer with a behavioural accumulator on its outputs.
module tb_mult_sequencer;

  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2*DW-1:0] acc;

  int checks   = 0;
  int failures = 0;

  mult_sequencer_if #(.DW(DW)) bus ();

  mult_sequencer #(.DW(DW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (bus.o_clean)       acc <= '0;
    else if (bus.o_enable) acc <= acc + bus.o_val;
  end

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] sum;
    logic [7:0]  en;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic logic [20:0] outs();
    return {bus.o_clean, bus.o_enable, bus.o_stop, bus.o_busy, bus.o_ready, bus.o_val};
  endfunction

  // Called away from the edge; returns at posedge+1 (first cycle after the accepting edge).
  task automatic launch(input logic [7:0] a, input logic [7:0] b);
    bus.i_start        = 1'b1;
    bus.i_multiplicand = a;
    bus.i_multiplier   = b;
    @(posedge clk);
    #1;
    bus.i_start        = 1'b0;
    bus.i_multiplicand = 8'($urandom);
    bus.i_multiplier   = 8'($urandom);
  endtask

  // Entered at posedge+1 of the LOAD cycle; returns at the negedge of the first DONE cycle.
  task automatic collect(input string nm, input logic [7:0] a, input logic [7:0] exp_en,
                         input logic [15:0] exp_sum, input bit keep_start);
    int lat = 0;
    int busy_cnt = 0;
    int clean_cnt = 0;
    int bad_val = 0;
    int bad_ctl = 0;
    logic clean_first = 1'b0;
    logic [7:0] en_pat = '0;
    logic [15:0] exp_val;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.o_ready) begin
        lat = i;
        break;
      end
      if (bus.o_busy) busy_cnt++;
      if (bus.o_clean) clean_cnt++;
      if (i == 1) clean_first = bus.o_clean;
      if (bus.o_stop || (bus.o_clean && bus.o_enable)) bad_ctl++;
      if (i >= 2 && i <= 9) begin
        en_pat[i-2] = bus.o_enable;
        exp_val = {8'h00, a} << (i - 2);
        if (bus.o_val !== exp_val) bad_val++;
      end
      @(posedge clk);
      #1;
      if (keep_start) begin
        bus.i_multiplicand = 8'($urandom);
        bus.i_multiplier   = 8'($urandom);
      end
    end
    chk({nm, " ready_latency"}, 32'(lat), 32'd10);
    chk({nm, " busy_cycles"}, 32'(busy_cnt), 32'd9);
    chk({nm, " clean_once_in_load"}, {30'd0, clean_first, 1'b0} | 32'(clean_cnt), 32'd3);
    chk({nm, " enable_pattern"}, {24'd0, en_pat}, {24'd0, exp_en});
    chk({nm, " val_errors"}, 32'(bad_val), 32'd0);
    chk({nm, " stop_or_overlap_errors"}, 32'(bad_ctl), 32'd0);
    chk({nm, " sum"}, {16'd0, acc}, {16'd0, exp_sum});
  endtask

  initial begin
    tbl[0] = '{a: 8'd13,  b: 8'd11,  sum: 16'd143,   en: 8'b0000_1011};
    tbl[1] = '{a: 8'd255, b: 8'd255, sum: 16'd65025, en: 8'b1111_1111};
    tbl[2] = '{a: 8'd0,   b: 8'd200, sum: 16'd0,     en: 8'b1100_1000};
    tbl[3] = '{a: 8'd77,  b: 8'd0,   sum: 16'd0,     en: 8'b0000_0000};
    tbl[4] = '{a: 8'd100, b: 8'd3,   sum: 16'd300,   en: 8'b0000_0011};
    tbl[5] = '{a: 8'd5,   b: 8'd9,   sum: 16'd45,    en: 8'b0000_1001};
    tbl[6] = '{a: 8'd1,   b: 8'd128, sum: 16'd128,   en: 8'b1000_0000};
    tbl[7] = '{a: 8'd128, b: 8'd2,   sum: 16'd256,   en: 8'b0000_0010};

    bus.i_start        = 1'b0;
    bus.i_multiplicand = '0;
    bus.i_multiplier   = '0;

    #12;
    chk("reset_outputs_held", {11'd0, outs()}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_outputs_release", {11'd0, outs()}, 32'd0);
    @(posedge clk);
    #1;
    chk("idle_outputs", {11'd0, outs()}, 32'd0);

    // First vector starts from IDLE, the rest restart straight from DONE.
    for (int v = 0; v < 8; v++) begin
      launch(tbl[v].a, tbl[v].b);
      collect($sformatf("vec%0d", v), tbl[v].a, tbl[v].en, tbl[v].sum, 1'b0);
    end

    // Start held high with operands churning: only the accepting edge matters.
    bus.i_start        = 1'b1;
    bus.i_multiplicand = 8'd12;
    bus.i_multiplier   = 8'd10;
    @(posedge clk);
    #1;
    bus.i_multiplicand = 8'($urandom);
    bus.i_multiplier   = 8'($urandom);
    collect("hold_start", 8'd12, 8'b0000_1010, 16'd120, 1'b1);
    bus.i_multiplicand = 8'd9;
    bus.i_multiplier   = 8'd11;
    @(posedge clk);
    #1;
    bus.i_start        = 1'b0;
    bus.i_multiplicand = 8'($urandom);
    bus.i_multiplier   = 8'($urandom);
    collect("hold_restart", 8'd9, 8'b0000_1011, 16'd99, 1'b0);

    // Reset during CALC cycle 4.
    launch(8'd50, 8'd60);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("pre_reset_busy", {31'd0, bus.o_busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("midop_reset_async", {11'd0, outs()}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midop_reset_release", {11'd0, outs()}, 32'd0);
    @(posedge clk);
    #1;
    chk("midop_reset_idle", {11'd0, outs()}, 32'd0);
    @(negedge clk);
    launch(8'd6, 8'd7);
    collect("after_reset", 8'd6, 8'b0000_0111, 16'd42, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
